cache_control: RTL and testbench
================================

// Module: cache_control
// PURPOSE
//  Control FSM for the 2-way write-back cache. Sits between the CPU-side
//  request port and the metadata/tag/data arrays, which are ff_array instances
//  with 1-cycle registered reads and active-low csb0/web0. Sequences hit
//  compare, victim writeback, line fill, re-read and a whole-cache clean
//  (flush). Tag compare, data muxing and pmem address formation live in the
//  datapath; this block drives selects and strobes only.
// PARAMETERS
//  s_index  4  set-index width; num_sets = 2**s_index; sizes flush_idx
// PORTS
//  clk0        in   1        clock
//  rst0        in   1        synchronous reset, active-low (0 = reset)
//  mem_read    in   1        CPU read request, held until mem_resp
//  mem_write   in   1        CPU write request, held until mem_resp; wins if both set
//  mem_resp    out  1        1-cycle completion pulse to CPU
//  hit_way     in   2        per-way (valid & tag match), valid in COMPARE
//  valid_way   in   2        valid bits of the currently read set
//  dirty_way   in   2        dirty bits of the currently read set
//  lru         in   1        LRU bit of the currently read set (= victim way)
//  pmem_read   out  1        line-fill request, held until pmem_resp
//  pmem_write  out  1        line-writeback request, held until pmem_resp
//  pmem_resp   in   1        memory completion pulse
//  arr_csb0    out  1        active-low chip select, all arrays
//  valid_web0  out  2        per-way valid write enable, active-low
//  dirty_web0  out  2        per-way dirty write enable, active-low
//  tag_web0    out  2        per-way tag write enable, active-low
//  data_web0   out  2        per-way data write enable, active-low
//  lru_web0    out  1        LRU write enable, active-low
//  valid_din0  out  1        value written to valid arrays
//  dirty_din0  out  1        value written to dirty arrays
//  lru_din0    out  1        value written to LRU array
//  data_sel    out  1        0 = CPU write merge, 1 = pmem line fill
//  paddr_sel   out  1        0 = CPU tag (fill), 1 = stored victim tag (writeback)
//  way_sel     out  1        way targeted by fill/writeback/flush
//  idx_sel     out  1        0 = CPU index, 1 = flush_idx to arrays
//  flush_idx   out  s_index  set currently being flushed
//  flush_req   in   1        level request to clean every dirty line
//  flush_done  out  1        1-cycle pulse when flush completes
// BEHAVIOUR
//  Defaults/reset: arr_csb0=1, all *_web0=1, all din/sel=0, mem_resp=0,
//   pmem_read=pmem_write=0, flush_done=0, flush_idx=0, state=IDLE.
//  rst0=0 in any state (incl. mid-pmem transaction) -> IDLE next edge; in-flight
//   pmem_resp after reset is ignored. pmem_resp outside WB/FILL/FLUSH_WB ignored.
//  Any *_web0=0 or read issue forces arr_csb0=0 in that cycle.
//  IDLE: mem_read|mem_write -> issue read (csb0=0), go COMPARE; else flush_req ->
//   FLUSH_READ (CPU request has priority over flush).
//  COMPARE: hit (|hit_way) -> mem_resp=1; lru_web0=0, lru_din0=~hit way;
//   write hit also data_web0[w]=0, dirty_web0[w]=0, dirty_din0=1, data_sel=0;
//   -> IDLE. Hit latency: request to mem_resp = 2 cycles.
//  Miss victim: lowest invalid way, else way lru; latched into way_sel.
//   victim valid & dirty -> WRITEBACK, else FILL.
//  WRITEBACK: pmem_write=1, paddr_sel=1 until pmem_resp -> FILL.
//  FILL: pmem_read=1, paddr_sel=0 until pmem_resp; on resp cycle data_web0,
//   tag_web0, valid_web0 (din 1), dirty_web0 (din 0) for way_sel, data_sel=1
//   -> RELOAD.
//  RELOAD: issue read -> COMPARE (guaranteed hit; write merges then).
//  FLUSH_READ: idx_sel=1, issue read of flush_idx -> FLUSH_CHECK.
//  FLUSH_CHECK: valid&dirty on way_sel -> FLUSH_WB; else advance.
//  FLUSH_WB: pmem_write=1, paddr_sel=1, idx_sel=1 until pmem_resp; resp cycle
//   dirty_web0[way_sel]=0, dirty_din0=0 (valid kept) -> advance.
//  Advance: way_sel 0->1 -> FLUSH_READ; way_sel 1 -> way_sel=0; flush_idx at
//   num_sets-1 -> flush_done=1, flush_idx=0, IDLE; else flush_idx+1 -> FLUSH_READ.
//  CPU requests arriving during flush wait until flush_done.
// TESTING
//  Cold read set 3: rst0 low 2 cycles, mem_read -> pmem_read, no pmem_write; resp -> RELOAD, mem_resp in COMPARE; lru_din0=1.
//  Write hit way1: mem_write -> mem_resp 2 cycles later; data_web0=2'b01, dirty_din0=1, lru_din0=0.
//  Miss, both ways valid, lru=0, dirty_way=2'b01 -> pmem_write paddr_sel=1, then pmem_read, fill way0.
//  Flush, s_index=2, dirty sets 1(way1) and 3(way0) -> exactly 2 pmem_write, flush_done once, flush_idx=0 after.
//  rst0 low during WRITEBACK with pmem_resp same cycle -> IDLE, pmem_write=0, no array writes.
//  flush_req and mem_read same cycle in IDLE -> CPU served first, flush starts after mem_resp.

Source files
------------

// File: rtl/cache_control.sv
// Control FSM for a 2-way write-back cache: hit compare, victim writeback,
// line fill, re-read and whole-cache flush. Drives array strobes and selects.
module cache_control #(
  parameter int s_index = 4
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               mem_resp,
  input  logic [1:0]         hit_way,
  input  logic [1:0]         valid_way,
  input  logic [1:0]         dirty_way,
  input  logic               lru,
  output logic               pmem_read,
  output logic               pmem_write,
  input  logic               pmem_resp,
  output logic               arr_csb0,
  output logic [1:0]         valid_web0,
  output logic [1:0]         dirty_web0,
  output logic [1:0]         tag_web0,
  output logic [1:0]         data_web0,
  output logic               lru_web0,
  output logic               valid_din0,
  output logic               dirty_din0,
  output logic               lru_din0,
  output logic               data_sel,
  output logic               paddr_sel,
  output logic               way_sel,
  output logic               idx_sel,
  output logic [s_index-1:0] flush_idx,
  input  logic               flush_req,
  output logic               flush_done
);

  typedef enum logic [2:0] {
    IDLE, COMPARE, WRITEBACK, FILL, RELOAD, FLUSH_READ, FLUSH_CHECK, FLUSH_WB
  } state_t;

  localparam logic [s_index-1:0] IDX_ONE = 1;

  state_t             state, state_nxt;
  logic               way_q, way_nxt;
  logic [s_index-1:0] fidx_q, fidx_nxt;
  logic               rd_issue, adv, hw, victim;

  assign flush_idx = fidx_q;

  always_ff @(posedge clk0) begin
    if (!rst0) begin
      state  <= IDLE;
      way_q  <= 1'b0;
      fidx_q <= '0;
    end else begin
      state  <= state_nxt;
      way_q  <= way_nxt;
      fidx_q <= fidx_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    way_nxt    = way_q;
    fidx_nxt   = fidx_q;
    rd_issue   = 1'b0;
    adv        = 1'b0;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    valid_web0 = 2'b11;
    dirty_web0 = 2'b11;
    tag_web0   = 2'b11;
    data_web0  = 2'b11;
    lru_web0   = 1'b1;
    valid_din0 = 1'b0;
    dirty_din0 = 1'b0;
    lru_din0   = 1'b0;
    data_sel   = 1'b0;
    paddr_sel  = 1'b0;
    way_sel    = 1'b0;
    idx_sel    = 1'b0;
    flush_done = 1'b0;
    // way0 wins if both ways ever report a hit
    hw         = ~hit_way[0];
    victim     = ~valid_way[0] ? 1'b0 : (~valid_way[1] ? 1'b1 : lru);

    // Outputs are held at their idle values while reset is asserted so an
    // in-flight transaction cannot strobe the arrays during the reset cycle.
    if (rst0) begin
      case (state)
        IDLE: begin
          if (mem_read | mem_write) begin
            rd_issue  = 1'b1;
            state_nxt = COMPARE;
          end else if (flush_req) begin
            way_nxt   = 1'b0;
            fidx_nxt  = '0;
            state_nxt = FLUSH_READ;
          end
        end
        COMPARE: begin
          if (|hit_way) begin
            mem_resp = 1'b1;
            lru_web0 = 1'b0;
            lru_din0 = ~hw;
            if (mem_write) begin
              data_web0[hw]  = 1'b0;
              dirty_web0[hw] = 1'b0;
              dirty_din0     = 1'b1;
            end
            state_nxt = IDLE;
          end else begin
            way_nxt   = victim;
            state_nxt = (valid_way[victim] & dirty_way[victim]) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          paddr_sel  = 1'b1;
          way_sel    = way_q;
          if (pmem_resp) state_nxt = FILL;
        end
        FILL: begin
          pmem_read = 1'b1;
          way_sel   = way_q;
          if (pmem_resp) begin
            data_web0[way_q]  = 1'b0;
            tag_web0[way_q]   = 1'b0;
            valid_web0[way_q] = 1'b0;
            dirty_web0[way_q] = 1'b0;
            valid_din0        = 1'b1;
            data_sel          = 1'b1;
            state_nxt         = RELOAD;
          end
        end
        RELOAD: begin
          rd_issue  = 1'b1;
          state_nxt = COMPARE;
        end
        FLUSH_READ: begin
          idx_sel   = 1'b1;
          way_sel   = way_q;
          rd_issue  = 1'b1;
          state_nxt = FLUSH_CHECK;
        end
        FLUSH_CHECK: begin
          way_sel = way_q;
          if (valid_way[way_q] & dirty_way[way_q]) state_nxt = FLUSH_WB;
          else                                      adv       = 1'b1;
        end
        FLUSH_WB: begin
          pmem_write = 1'b1;
          paddr_sel  = 1'b1;
          idx_sel    = 1'b1;
          way_sel    = way_q;
          if (pmem_resp) begin
            dirty_web0[way_q] = 1'b0;
            adv               = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase

      // Step to the next (set, way); way0 then way1 of each set.
      if (adv) begin
        if (!way_q) begin
          way_nxt   = 1'b1;
          state_nxt = FLUSH_READ;
        end else begin
          way_nxt = 1'b0;
          if (fidx_q == '1) begin
            flush_done = 1'b1;
            fidx_nxt   = '0;
            state_nxt  = IDLE;
          end else begin
            fidx_nxt  = fidx_q + IDX_ONE;
            state_nxt = FLUSH_READ;
          end
        end
      end
    end

    arr_csb0 = ~(rd_issue | ~&{valid_web0, dirty_web0, tag_web0, data_web0, lru_web0});
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: hits, misses with/without writeback,
// victim choice, reset mid-transaction, flush and request/flush priority.
module tb_cache_control;
  localparam int SI = 2;

  logic          clk0 = 1'b0, rst0 = 1'b0;
  logic          mem_read, mem_write, mem_resp;
  logic [1:0]    hit_way, valid_way, dirty_way;
  logic          lru, pmem_read, pmem_write, pmem_resp, arr_csb0;
  logic [1:0]    valid_web0, dirty_web0, tag_web0, data_web0;
  logic          lru_web0, valid_din0, dirty_din0, lru_din0;
  logic          data_sel, paddr_sel, way_sel, idx_sel, flush_req, flush_done;
  logic [SI-1:0] flush_idx;

  int vectors = 0, miscompares = 0;
  int n_wb, n_done, n_resp;
  logic [1:0] dtab [4];
  logic [4:0] wb_rec [2];

  cache_control #(.s_index(SI)) dut (
    .clk0(clk0), .rst0(rst0), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .hit_way(hit_way), .valid_way(valid_way),
    .dirty_way(dirty_way), .lru(lru), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .arr_csb0(arr_csb0),
    .valid_web0(valid_web0), .dirty_web0(dirty_web0), .tag_web0(tag_web0),
    .data_web0(data_web0), .lru_web0(lru_web0), .valid_din0(valid_din0),
    .dirty_din0(dirty_din0), .lru_din0(lru_din0), .data_sel(data_sel),
    .paddr_sel(paddr_sel), .way_sel(way_sel), .idx_sel(idx_sel),
    .flush_idx(flush_idx), .flush_req(flush_req), .flush_done(flush_done)
  );

  always #5 clk0 = ~clk0;

  task automatic step;
    @(posedge clk0); #1;
  endtask

  task automatic idle_inputs;
    mem_read = 0; mem_write = 0; hit_way = 0; valid_way = 0; dirty_way = 0;
    lru = 0; pmem_resp = 0; flush_req = 0;
  endtask

  task automatic reset_cycle;
    idle_inputs(); rst0 = 0; step(); rst0 = 1;
  endtask

  // Walks a flush already in FLUSH_READ, answering each writeback at once.
  task automatic run_flush;
    n_wb = 0; n_done = 0; n_resp = 0;
    for (int c = 0; c < 100 && n_done == 0; c++) begin
      valid_way = 2'b11; dirty_way = dtab[flush_idx]; #1;
      pmem_resp = pmem_write; #1;
      if (pmem_write && pmem_resp) begin
        if (n_wb < 2) wb_rec[n_wb] = {flush_idx, way_sel, dirty_web0};
        n_wb++;
      end
      if (mem_resp) n_resp++;
      if (flush_done) n_done++;
      step(); pmem_resp = 0;
    end
  endtask

  task automatic test_reset;
    idle_inputs(); mem_read = 1; rst0 = 0;
    step(); step(); #1;
    vectors++; if ({arr_csb0, valid_web0, dirty_web0, tag_web0, data_web0, lru_web0} !== 10'h3FF) begin
      miscompares++; $display("FAIL reset_strobes got %b want %b", {arr_csb0, valid_web0, dirty_web0, tag_web0, data_web0, lru_web0}, 10'h3FF); end
    vectors++; if ({valid_din0, dirty_din0, lru_din0, data_sel, paddr_sel, way_sel, idx_sel, mem_resp, pmem_read, pmem_write, flush_done, flush_idx} !== 13'b0) begin
      miscompares++; $display("FAIL reset_outputs got %b want 0", {valid_din0, dirty_din0, lru_din0, data_sel, paddr_sel, way_sel, idx_sel, mem_resp, pmem_read, pmem_write, flush_done, flush_idx}); end
    mem_read = 0; rst0 = 1; #1;
    vectors++; if (arr_csb0 !== 1'b1) begin
      miscompares++; $display("FAIL reset_idle_csb got %b want 1", arr_csb0); end
  endtask

  task automatic test_cold_read;
    idle_inputs(); mem_read = 1; #1;
    vectors++; if ({arr_csb0, mem_resp} !== 2'b00) begin
      miscompares++; $display("FAIL cold_issue got %b want 00", {arr_csb0, mem_resp}); end
    step(); valid_way = 2'b00; dirty_way = 2'b11; lru = 1; #1;
    vectors++; if ({mem_resp, pmem_read, pmem_write, lru_web0} !== 4'b0001) begin
      miscompares++; $display("FAIL cold_compare got %b want 0001", {mem_resp, pmem_read, pmem_write, lru_web0}); end
    step();
    vectors++; if ({pmem_read, pmem_write, paddr_sel, way_sel} !== 4'b1000) begin
      miscompares++; $display("FAIL cold_fill got %b want 1000", {pmem_read, pmem_write, paddr_sel, way_sel}); end
    step();
    vectors++; if ({pmem_read, data_web0} !== 3'b111) begin
      miscompares++; $display("FAIL cold_fill_hold got %b want 111", {pmem_read, data_web0}); end
    pmem_resp = 1; #1;
    vectors++; if ({data_web0, tag_web0, valid_web0, dirty_web0} !== 8'b10101010) begin
      miscompares++; $display("FAIL cold_fill_webs got %b want 10101010", {data_web0, tag_web0, valid_web0, dirty_web0}); end
    vectors++; if ({valid_din0, dirty_din0, data_sel, arr_csb0} !== 4'b1010) begin
      miscompares++; $display("FAIL cold_fill_din got %b want 1010", {valid_din0, dirty_din0, data_sel, arr_csb0}); end
    step(); pmem_resp = 0; #1;
    vectors++; if ({arr_csb0, pmem_read, mem_resp} !== 3'b000) begin
      miscompares++; $display("FAIL cold_reload got %b want 000", {arr_csb0, pmem_read, mem_resp}); end
    step(); hit_way = 2'b01; valid_way = 2'b01; dirty_way = 0; #1;
    vectors++; if ({mem_resp, lru_web0, lru_din0, data_web0} !== 5'b10111) begin
      miscompares++; $display("FAIL cold_hit got %b want 10111", {mem_resp, lru_web0, lru_din0, data_web0}); end
    step(); idle_inputs(); #1;
    vectors++; if ({mem_resp, arr_csb0} !== 2'b01) begin
      miscompares++; $display("FAIL cold_done got %b want 01", {mem_resp, arr_csb0}); end
  endtask

  task automatic test_write_hit;
    idle_inputs(); mem_write = 1; #1;
    vectors++; if (mem_resp !== 1'b0) begin
      miscompares++; $display("FAIL wr_early_resp got %b want 0", mem_resp); end
    step(); hit_way = 2'b10; valid_way = 2'b11; lru = 1; #1;
    vectors++; if ({mem_resp, data_web0, dirty_web0, dirty_din0, lru_din0, lru_web0, data_sel, arr_csb0} !== 10'b1_01_01_1_0_0_0_0) begin
      miscompares++; $display("FAIL wr_hit got %b want 1010110000", {mem_resp, data_web0, dirty_web0, dirty_din0, lru_din0, lru_web0, data_sel, arr_csb0}); end
    step(); idle_inputs(); #1;
    vectors++; if (mem_resp !== 1'b0) begin
      miscompares++; $display("FAIL wr_resp_pulse got %b want 0", mem_resp); end
  endtask

  task automatic test_dirty_miss;
    idle_inputs(); mem_read = 1;
    step(); valid_way = 2'b11; lru = 0; dirty_way = 2'b01; #1;
    vectors++; if (mem_resp !== 1'b0) begin
      miscompares++; $display("FAIL dm_resp got %b want 0", mem_resp); end
    step();
    vectors++; if ({pmem_write, pmem_read, paddr_sel, way_sel} !== 4'b1010) begin
      miscompares++; $display("FAIL dm_wb got %b want 1010", {pmem_write, pmem_read, paddr_sel, way_sel}); end
    pmem_resp = 1; #1;
    vectors++; if ({data_web0, dirty_web0, tag_web0, valid_web0} !== 8'hFF) begin
      miscompares++; $display("FAIL dm_wb_nowrite got %b want ff", {data_web0, dirty_web0, tag_web0, valid_web0}); end
    step(); pmem_resp = 0; #1;
    vectors++; if ({pmem_write, pmem_read, paddr_sel, way_sel} !== 4'b0100) begin
      miscompares++; $display("FAIL dm_fill got %b want 0100", {pmem_write, pmem_read, paddr_sel, way_sel}); end
    pmem_resp = 1; #1;
    vectors++; if ({data_web0, tag_web0} !== 4'b1010) begin
      miscompares++; $display("FAIL dm_fill_way0 got %b want 1010", {data_web0, tag_web0}); end
    step(); pmem_resp = 0;
    step(); hit_way = 2'b01; valid_way = 2'b11; dirty_way = 0; #1;
    vectors++; if (mem_resp !== 1'b1) begin
      miscompares++; $display("FAIL dm_hit got %b want 1", mem_resp); end
    step(); idle_inputs();
  endtask

  task automatic test_victim_select;
    idle_inputs(); mem_read = 1;
    step(); valid_way = 2'b01; lru = 0; dirty_way = 2'b00;
    step();
    vectors++; if ({pmem_read, pmem_write, way_sel} !== 3'b101) begin
      miscompares++; $display("FAIL victim_invalid got %b want 101", {pmem_read, pmem_write, way_sel}); end
    reset_cycle(); mem_read = 1;
    step(); valid_way = 2'b11; lru = 1; dirty_way = 2'b01;
    step();
    vectors++; if ({pmem_read, pmem_write, way_sel} !== 3'b101) begin
      miscompares++; $display("FAIL victim_lru got %b want 101", {pmem_read, pmem_write, way_sel}); end
    reset_cycle();
  endtask

  task automatic test_reset_in_wb;
    idle_inputs(); mem_read = 1;
    step(); valid_way = 2'b11; lru = 0; dirty_way = 2'b01;
    step();
    vectors++; if (pmem_write !== 1'b1) begin
      miscompares++; $display("FAIL rwb_enter got %b want 1", pmem_write); end
    rst0 = 0; pmem_resp = 1; mem_read = 0; #1;
    vectors++; if ({pmem_write, arr_csb0, data_web0, tag_web0, valid_web0, dirty_web0} !== 10'b0111111111) begin
      miscompares++; $display("FAIL rwb_gated got %b want 0111111111", {pmem_write, arr_csb0, data_web0, tag_web0, valid_web0, dirty_web0}); end
    step(); rst0 = 1; #1;
    vectors++; if ({pmem_read, pmem_write, arr_csb0, mem_resp} !== 4'b0010) begin
      miscompares++; $display("FAIL rwb_idle got %b want 0010", {pmem_read, pmem_write, arr_csb0, mem_resp}); end
    step(); pmem_resp = 0; #1;
    vectors++; if ({pmem_read, pmem_write, arr_csb0, mem_resp} !== 4'b0010) begin
      miscompares++; $display("FAIL rwb_stale_resp got %b want 0010", {pmem_read, pmem_write, arr_csb0, mem_resp}); end
    idle_inputs();
  endtask

  task automatic test_flush;
    idle_inputs();
    dtab[0] = 2'b00; dtab[1] = 2'b10; dtab[2] = 2'b00; dtab[3] = 2'b01;
    flush_req = 1; #1;
    vectors++; if (arr_csb0 !== 1'b1) begin
      miscompares++; $display("FAIL fl_idle_csb got %b want 1", arr_csb0); end
    step(); flush_req = 0;
    run_flush();
    vectors++; if (n_wb !== 2) begin
      miscompares++; $display("FAIL fl_wb_count got %0d want 2", n_wb); end
    vectors++; if (n_done !== 1) begin
      miscompares++; $display("FAIL fl_done_count got %0d want 1", n_done); end
    vectors++; if ({wb_rec[0], wb_rec[1]} !== {2'd1, 1'b1, 2'b01, 2'd3, 1'b0, 2'b10}) begin
      miscompares++; $display("FAIL fl_wb_target got %b want %b", {wb_rec[0], wb_rec[1]}, {2'd1, 1'b1, 2'b01, 2'd3, 1'b0, 2'b10}); end
    vectors++; if ({flush_idx, flush_done, arr_csb0} !== 4'b0001) begin
      miscompares++; $display("FAIL fl_after got %b want 0001", {flush_idx, flush_done, arr_csb0}); end
  endtask

  task automatic test_priority;
    idle_inputs(); mem_read = 1; flush_req = 1; #1;
    vectors++; if ({idx_sel, arr_csb0} !== 2'b00) begin
      miscompares++; $display("FAIL pri_issue got %b want 00", {idx_sel, arr_csb0}); end
    step(); hit_way = 2'b01; valid_way = 2'b01; #1;
    vectors++; if ({mem_resp, idx_sel} !== 2'b10) begin
      miscompares++; $display("FAIL pri_cpu_first got %b want 10", {mem_resp, idx_sel}); end
    step(); mem_read = 0; hit_way = 0; #1;
    vectors++; if ({arr_csb0, idx_sel, mem_resp} !== 3'b100) begin
      miscompares++; $display("FAIL pri_idle got %b want 100", {arr_csb0, idx_sel, mem_resp}); end
    step(); #1;
    vectors++; if ({idx_sel, arr_csb0, flush_idx, way_sel} !== 5'b10000) begin
      miscompares++; $display("FAIL pri_flush_start got %b want 10000", {idx_sel, arr_csb0, flush_idx, way_sel}); end
    flush_req = 0; mem_read = 1;
    for (int i = 0; i < 4; i++) dtab[i] = 2'b00;
    run_flush();
    vectors++; if ({n_wb[1:0], n_done[1:0], n_resp[1:0]} !== 6'b00_01_00) begin
      miscompares++; $display("FAIL pri_clean_flush wb=%0d done=%0d resp=%0d want 0 1 0", n_wb, n_done, n_resp); end
    hit_way = 0; #1;
    vectors++; if ({arr_csb0, mem_resp, flush_done} !== 3'b000) begin
      miscompares++; $display("FAIL pri_waiting_req got %b want 000", {arr_csb0, mem_resp, flush_done}); end
    step(); hit_way = 2'b01; valid_way = 2'b01; #1;
    vectors++; if (mem_resp !== 1'b1) begin
      miscompares++; $display("FAIL pri_cpu_after got %b want 1", mem_resp); end
    step(); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_miss();
    test_victim_select();
    test_reset_in_wb();
    test_flush();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
